// File: rtl/offnariscv_pkg.sv
// offnariscv_pkg: shared core widths and the instruction queue entry type.
package offnariscv_pkg;
   localparam int XLEN = 32;
   localparam int ILEN = 32;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
      logic            fault;
   } inst_queue_entry_t;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: IFU-to-decode instruction FIFO, dropped wholesale on flush.
// INST_QUEUE_BYPASS_EN enables a 0-cycle path from if_* to id_* when empty.
module inst_queue
   import offnariscv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = offnariscv_pkg::XLEN,
   parameter int ILEN  = offnariscv_pkg::ILEN
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       if_valid,
   output logic                       if_ready,
   input  logic [XLEN-1:0]            if_pc,
   input  logic [ILEN-1:0]            if_inst,
   input  logic                       if_fault,
   output logic                       id_valid,
   input  logic                       id_ready,
   output logic [XLEN-1:0]            id_pc,
   output logic [ILEN-1:0]            id_inst,
   output logic                       id_fault,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("inst_queue: DEPTH must be a power of two >= 2");
   end
   if (XLEN != offnariscv_pkg::XLEN || ILEN != offnariscv_pkg::ILEN) begin : g_bad_width
      $error("inst_queue: XLEN/ILEN must match offnariscv_pkg");
   end
   inst_queue_entry_t storage [DEPTH];
   inst_queue_entry_t head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic full, empty, push, pop, byp;
   assign empty    = wr_ptr == rd_ptr;
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count    = wr_ptr - rd_ptr;
   assign if_ready = !full;
   assign head     = storage[rd_ptr[AW-1:0]];
`ifdef INST_QUEUE_BYPASS_EN
   assign byp = empty && if_valid && !flush;
`else
   assign byp = 1'b0;
`endif
   always_comb begin
      id_valid = (!empty || byp) && !flush;
      id_pc    = byp ? if_pc    : head.pc;
      id_inst  = byp ? if_inst  : head.inst;
      id_fault = byp ? if_fault : head.fault;
      push     = if_valid && if_ready && !flush && !(byp && id_ready);
      pop      = id_valid && id_ready && !byp;
   end
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push);
         rd_ptr <= rd_ptr + PW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) storage[wr_ptr[AW-1:0]] <= '{pc: if_pc, inst: if_inst, fault: if_fault};
   end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed checks of reset, fill, drain, streaming, flush and bypass.
module tb_inst_queue;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        if_valid = 1'b0;
   logic        if_ready;
   logic [31:0] if_pc = '0;
   logic [31:0] if_inst = '0;
   logic        if_fault = 1'b0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_fault;
   logic [2:0]  count;
   int n_chk = 0;
   int n_fail = 0;

   inst_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst), .if_fault(if_fault),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst), .id_fault(id_fault),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] pc, input logic f);
      if_valid = 1'b1;
      if_pc    = pc;
      if_inst  = ~pc;
      if_fault = f;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
      n_chk++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready got %b want 1", if_ready); end
      n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
   endtask

   task automatic test_fill();
      id_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         present(32'h100 + 32'(4 * i), 1'b0);
         step();
         if (i == 0) begin
            n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_fail++; $display("FAIL fill_latency got v=%b pc=%h want v=1 pc=100", id_valid, id_pc); end
         end
      end
      n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", count); end
      n_chk++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL fill_if_ready got %b want 0", if_ready); end
      present(32'h110, 1'b0);
      step();
      n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_overflow_count got %0d want 4", count); end
      n_chk++; if (id_pc !== 32'h100) begin n_fail++; $display("FAIL fill_head got %h want 100", id_pc); end
      if_valid = 1'b0;
   endtask

   task automatic test_drain();
      id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h100 + 32'(4 * i) || id_inst !== ~(32'h100 + 32'(4 * i)))
            begin n_fail++; $display("FAIL drain_head%0d got v=%b pc=%h want v=1 pc=%h", i, id_valid, id_pc, 32'h100 + 32'(4 * i)); end
         step();
         n_chk++; if (count !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_count%0d got %0d want %0d", i, count, 3 - i); end
         if (i == 0) begin
            n_chk++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL drain_if_ready got %b want 1", if_ready); end
         end
      end
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", id_valid); end
      id_ready = 1'b0;
   endtask

   task automatic test_concurrent();
      logic [31:0] qpc[$];
      logic        qf[$];
      id_ready = 1'b0;
      present(32'h1F0, 1'b0); qpc.push_back(32'h1F0); qf.push_back(1'b0); step();
      present(32'h1F4, 1'b1); qpc.push_back(32'h1F4); qf.push_back(1'b1); step();
      n_chk++; if (count !== 3'd2) begin n_fail++; $display("FAIL conc_start_count got %0d want 2", count); end
      id_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         present(32'h200 + 32'(4 * i), i[0]);
         qpc.push_back(32'h200 + 32'(4 * i)); qf.push_back(i[0]);
         n_chk++; if (id_valid !== 1'b1 || id_pc !== qpc[0] || id_fault !== qf[0])
            begin n_fail++; $display("FAIL conc_head%0d got pc=%h f=%b want pc=%h f=%b", i, id_pc, id_fault, qpc[0], qf[0]); end
         void'(qpc.pop_front()); void'(qf.pop_front());
         step();
         n_chk++; if (count !== 3'd2) begin n_fail++; $display("FAIL conc_count%0d got %0d want 2", i, count); end
      end
      if_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_chk++; if (id_pc !== qpc[0] || id_fault !== qf[0])
            begin n_fail++; $display("FAIL conc_tail%0d got pc=%h f=%b want pc=%h f=%b", i, id_pc, id_fault, qpc[0], qf[0]); end
         void'(qpc.pop_front()); void'(qf.pop_front());
         step();
      end
      n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL conc_end_count got %0d want 0", count); end
      id_ready = 1'b0;
   endtask

   task automatic test_flush();
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         present(32'h280 + 32'(4 * i), 1'b0);
         step();
      end
      n_chk++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d want 3", count); end
      present(32'h300, 1'b0);
      id_ready = 1'b1;
      flush = 1'b1;
      #1;
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_id_valid got %b want 0", id_valid); end
      n_chk++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_if_ready got %b want 1", if_ready); end
      step();
      flush = 1'b0;
      if_valid = 1'b0;
      id_ready = 1'b0;
      #1;
      n_chk++; if (count !== 3'd0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_post got count=%0d v=%b want 0/0", count, id_valid); end
      present(32'h500, 1'b0);
      step();
      if_valid = 1'b0;
      n_chk++; if (count !== 3'd1 || id_pc !== 32'h500) begin n_fail++; $display("FAIL flush_after got count=%0d pc=%h want 1/500", count, id_pc); end
      id_ready = 1'b1;
      step();
      id_ready = 1'b0;
      rst = 1'b1; flush = 1'b1;
      present(32'h600, 1'b0);
      step();
      rst = 1'b0; flush = 1'b0; if_valid = 1'b0;
      #1;
      n_chk++; if (count !== 3'd0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flush got count=%0d v=%b want 0/0", count, id_valid); end
   endtask

   task automatic test_bypass();
      present(32'h400, 1'b1);
      id_ready = 1'b1;
      #1;
`ifdef INST_QUEUE_BYPASS_EN
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h400 || id_fault !== 1'b1)
         begin n_fail++; $display("FAIL bypass_same got v=%b pc=%h f=%b want 1/400/1", id_valid, id_pc, id_fault); end
      step();
      if_valid = 1'b0;
      n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL bypass_count got %0d want 0", count); end
`else
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_same got v=%b want 0", id_valid); end
      step();
      if_valid = 1'b0;
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h400 || id_fault !== 1'b1 || count !== 3'd1)
         begin n_fail++; $display("FAIL bypass_next got v=%b pc=%h f=%b count=%0d want 1/400/1/1", id_valid, id_pc, id_fault, count); end
      step();
      n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL bypass_drain got %0d want 0", count); end
`endif
      id_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_concurrent();
      test_flush();
      test_bypass();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
